// File: rtl/ram_bus_master_if.sv
// Client request/response and RAM control signals for the MAR/MDR sysbus master.
// The shared tri-state data bus is kept outside the interface as a plain inout.
interface ram_bus_master_if #(
  parameter int WORD_W = 8,
  parameter int OP_W   = 3
);
  localparam int ADDR_W = WORD_W - OP_W;

  // Client request channel
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;

  // Client response channel
  logic              rsp_valid;
  logic [WORD_W-1:0] rsp_rdata;
  logic              rsp_err;

  // Bus arbitration
  logic              bus_req;
  logic              bus_gnt;

  // RAM strobes
  logic              load_MAR;
  logic              load_MDR;
  logic              CS;
  logic              R_NW;
  logic              MDR_bus;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, bus_gnt,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output bus_req, load_MAR, load_MDR, CS, R_NW, MDR_bus
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, bus_gnt,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  bus_req, load_MAR, load_MDR, CS, R_NW, MDR_bus
  );
endinterface

// File: rtl/ram_bus_master.sv
// Sysbus initiator: turns one valid/ready word request into the MAR/MDR
// strobe sequence on the shared tri-state bus and returns a 1-cycle response.
// Strobes and bus drive are decoded from the state register and bus_gnt, so a
// grant arriving mid-cycle is used in that same cycle.
module ram_bus_master #(
  parameter int WORD_W = 8,
  parameter int OP_W   = 3
) (
  input  logic                clock,
  input  logic                n_reset,
  ram_bus_master_if.master    bus,
  inout  wire  [WORD_W-1:0]   sysbus
);

  localparam int ADDR_W = WORD_W - OP_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_ACCESS,
    S_RDATA,
    S_DONE
  } state_t;

  state_t            state_q;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [WORD_W-1:0] rdata_q;
  logic              err_q;

  logic              drive_en;
  logic [WORD_W-1:0] drive_val;

  // Master drives the bus only while a granted address or write-data phase is active.
  assign sysbus = drive_en ? drive_val : {WORD_W{1'bz}};

  // Transaction sequencing and capture of the request and read data.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            write_q <= bus.req_write;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            rdata_q <= '0;
            // RAM occupies only the upper half of the address space.
            err_q   <= ~bus.req_addr[ADDR_W-1];
            state_q <= bus.req_addr[ADDR_W-1] ? S_ADDR : S_DONE;
          end
        end
        S_ADDR: begin
          if (bus.bus_gnt) begin
            state_q <= write_q ? S_WDATA : S_ACCESS;
          end
        end
        S_WDATA: begin
          if (bus.bus_gnt) begin
            state_q <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          // The RAM cycle itself does not use the bus, so it never stalls.
          state_q <= write_q ? S_DONE : S_RDATA;
        end
        S_RDATA: begin
          if (bus.bus_gnt) begin
            rdata_q <= sysbus;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Output decode from the current state and the live grant.
  always_comb begin
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_rdata = '0;
    bus.rsp_err   = 1'b0;
    bus.bus_req   = 1'b0;
    bus.load_MAR  = 1'b0;
    bus.load_MDR  = 1'b0;
    bus.CS        = 1'b0;
    bus.R_NW      = 1'b1;
    bus.MDR_bus   = 1'b0;
    drive_en      = 1'b0;
    drive_val     = '0;
    case (state_q)
      S_IDLE: begin
        bus.req_ready = 1'b1;
      end
      S_ADDR: begin
        bus.bus_req = 1'b1;
        if (bus.bus_gnt) begin
          drive_en     = 1'b1;
          drive_val    = {{OP_W{1'b0}}, addr_q};
          bus.load_MAR = 1'b1;
        end
      end
      S_WDATA: begin
        bus.bus_req = 1'b1;
        if (bus.bus_gnt) begin
          drive_en     = 1'b1;
          drive_val    = wdata_q;
          bus.load_MDR = 1'b1;
        end
      end
      S_ACCESS: begin
        bus.bus_req = 1'b1;
        bus.CS      = 1'b1;
        bus.R_NW    = ~write_q;
      end
      S_RDATA: begin
        // RAM owns the bus here; the master only listens.
        bus.bus_req = 1'b1;
        bus.MDR_bus = bus.bus_gnt;
      end
      S_DONE: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_rdata = rdata_q;
        bus.rsp_err   = err_q;
      end
      default: begin
        bus.req_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_bus_master.sv
// Bench for ram_bus_master: a behavioural RAM on the sysbus, a memory/latency
// reference model, directed scenarios and randomized transactions.
module tb_ram_bus_master;
  localparam int WORD_W = 8;
  localparam int OP_W   = 3;
  localparam int ADDR_W = WORD_W - OP_W;

  logic clock   = 1'b0;
  logic n_reset = 1'b0;
  wire  [WORD_W-1:0] sysbus;

  ram_bus_master_if #(.WORD_W(WORD_W), .OP_W(OP_W)) bif ();

  ram_bus_master #(.WORD_W(WORD_W), .OP_W(OP_W)) dut (
    .clock   (clock),
    .n_reset (n_reset),
    .bus     (bif),
    .sysbus  (sysbus)
  );

  always #5 clock = ~clock;

  // Behavioural RAM: MAR/MDR registers and a 32-word array
  logic [WORD_W-1:0] mem [32];
  logic [ADDR_W-1:0] mar;
  logic [WORD_W-1:0] mdr;

  assign sysbus = bif.MDR_bus ? mdr : {WORD_W{1'bz}};

  always @(posedge clock) begin
    if (bif.load_MAR) mar <= sysbus[ADDR_W-1:0];
    if (bif.load_MDR) mdr <= sysbus;
    if (bif.CS) begin
      if (bif.R_NW) mdr <= mem[mar];
      else          mem[mar] <= mdr;
    end
  end

  // Reference model: expected memory contents
  logic [WORD_W-1:0] ref_mem [32];

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Protocol monitor: strobes mutually exclusive, no bus use without grant
  always @(negedge clock) begin
    if (n_reset) begin
      check("strobe_onehot",
            32'($countones({bif.load_MAR, bif.load_MDR, bif.CS, bif.MDR_bus}) <= 1), 32'd1);
      check("bus_use_without_gnt",
            32'((bif.load_MAR | bif.load_MDR | bif.MDR_bus) & ~bif.bus_gnt), 32'd0);
    end
  end

  // One complete transaction with grant withheld for 'stall' cycles in ADDR.
  task automatic run_txn(input bit wr, input logic [ADDR_W-1:0] a,
                         input logic [WORD_W-1:0] d, input int stall, input string tag);
    int n_mar, n_mdr, n_cs, n_mdrbus, n_req;
    bit got, err_exp;
    int lat_exp;
    logic [WORD_W-1:0] rd_exp;
    err_exp = !a[ADDR_W-1];
    lat_exp = err_exp ? 1 : 4 + stall;
    rd_exp  = (wr || err_exp) ? '0 : ref_mem[a];
    n_mar = 0; n_mdr = 0; n_cs = 0; n_mdrbus = 0; n_req = 0; got = 1'b0;

    @(negedge clock);
    for (int k = 0; k < 20 && !bif.req_ready; k++) @(negedge clock);
    check({tag, "_ready"}, 32'(bif.req_ready), 32'd1);
    bif.req_valid = 1'b1;
    bif.req_write = wr;
    bif.req_addr  = a;
    bif.req_wdata = d;
    bif.bus_gnt   = (stall == 0);
    @(posedge clock); #1;
    // Scramble the request after acceptance; it must have no effect.
    bif.req_valid = 1'b0;
    bif.req_write = ~wr;
    bif.req_addr  = ~a;
    bif.req_wdata = ~d;

    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clock);
      if (bif.bus_req) n_req++;
      if (bif.load_MAR) begin
        n_mar++;
        check({tag, "_mar_value"}, 32'(sysbus), 32'({{OP_W{1'b0}}, a}));
      end
      if (bif.load_MDR) begin
        n_mdr++;
        check({tag, "_mdr_value"}, 32'(sysbus), 32'(d));
      end
      if (bif.CS) begin
        n_cs++;
        check({tag, "_r_nw"}, 32'(bif.R_NW), 32'(!wr));
      end
      if (bif.MDR_bus) n_mdrbus++;
      if (bif.rsp_valid) begin
        got = 1'b1;
        check({tag, "_latency"}, 32'(cyc), 32'(lat_exp));
        check({tag, "_err"}, 32'(bif.rsp_err), 32'(err_exp));
        check({tag, "_rdata"}, 32'(bif.rsp_rdata), 32'(rd_exp));
        break;
      end
      @(posedge clock); #1;
      if (cyc == stall) bif.bus_gnt = 1'b1;
    end
    check({tag, "_rsp_seen"}, 32'(got), 32'd1);
    check({tag, "_n_load_MAR"}, 32'(n_mar), err_exp ? 32'd0 : 32'd1);
    check({tag, "_n_load_MDR"}, 32'(n_mdr), (!err_exp && wr) ? 32'd1 : 32'd0);
    check({tag, "_n_CS"}, 32'(n_cs), err_exp ? 32'd0 : 32'd1);
    check({tag, "_n_MDR_bus"}, 32'(n_mdrbus), (!err_exp && !wr) ? 32'd1 : 32'd0);
    check({tag, "_n_bus_req"}, 32'(n_req), err_exp ? 32'd0 : 32'(lat_exp - 1));
    @(negedge clock);
    check({tag, "_rsp_pulse"}, 32'(bif.rsp_valid), 32'd0);
    check({tag, "_idle_ready"}, 32'(bif.req_ready), 32'd1);
    if (wr && !err_exp) ref_mem[a] = d;
    bif.bus_gnt = 1'b1;
  endtask

  initial begin
    int rsp_cycles[$];
    bit rdy4, rdy5;

    for (int i = 0; i < 32; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    bif.req_valid = 1'b0;
    bif.req_write = 1'b0;
    bif.req_addr  = '0;
    bif.req_wdata = '0;
    bif.bus_gnt   = 1'b1;

    // Reset state
    #2;
    check("rst_req_ready", 32'(bif.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bif.rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(bif.rsp_rdata), 32'd0);
    check("rst_rsp_err", 32'(bif.rsp_err), 32'd0);
    check("rst_bus_req", 32'(bif.bus_req), 32'd0);
    check("rst_strobes", 32'({bif.load_MAR, bif.load_MDR, bif.CS, bif.MDR_bus}), 32'd0);
    check("rst_R_NW", 32'(bif.R_NW), 32'd1);
    repeat (2) @(negedge clock);
    n_reset = 1'b1;

    // Directed transactions
    run_txn(1'b1, 5'h13, 8'h5A, 0, "wr13");
    run_txn(1'b0, 5'h13, 8'h00, 0, "rd13");
    run_txn(1'b0, 5'h05, 8'h00, 0, "rd05_err");
    run_txn(1'b1, 5'h05, 8'hEE, 0, "wr05_err");
    run_txn(1'b0, 5'h13, 8'h00, 3, "rd13_stall");
    run_txn(1'b1, 5'h1F, 8'hC3, 3, "wr1F_stall");
    run_txn(1'b0, 5'h1F, 8'h00, 2, "rd1F_stall");

    // Back-to-back writes with req_valid held high
    @(negedge clock);
    bif.req_valid = 1'b1;
    bif.req_write = 1'b1;
    bif.req_addr  = 5'h10;
    bif.req_wdata = 8'h11;
    @(posedge clock); #1;
    bif.req_addr  = 5'h11;
    bif.req_wdata = 8'h22;
    rdy4 = 1'b0; rdy5 = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clock);
      if (bif.rsp_valid) rsp_cycles.push_back(cyc);
      if (cyc == 4) rdy4 = bif.req_ready;
      if (cyc == 5) rdy5 = bif.req_ready;
      @(posedge clock); #1;
      if (cyc == 5) bif.req_valid = 1'b0;
    end
    check("b2b_rsp_count", 32'(rsp_cycles.size()), 32'd2);
    if (rsp_cycles.size() == 2) begin
      check("b2b_rsp1_cycle", 32'(rsp_cycles[0]), 32'd4);
      check("b2b_rsp2_cycle", 32'(rsp_cycles[1]), 32'd9);
    end
    check("b2b_ready_in_done", 32'(rdy4), 32'd0);
    check("b2b_ready_after_done", 32'(rdy5), 32'd1);
    ref_mem[5'h10] = 8'h11;
    ref_mem[5'h11] = 8'h22;
    run_txn(1'b0, 5'h10, 8'h00, 0, "rd10_b2b");
    run_txn(1'b0, 5'h11, 8'h00, 0, "rd11_b2b");

    // Reset during ACCESS
    @(negedge clock);
    bif.req_valid = 1'b1;
    bif.req_write = 1'b1;
    bif.req_addr  = 5'h1C;
    bif.req_wdata = 8'h77;
    @(posedge clock); #1;
    bif.req_valid = 1'b0;
    repeat (3) @(negedge clock);
    check("mid_rst_in_access", 32'(bif.CS), 32'd1);
    n_reset = 1'b0;
    #1;
    check("mid_rst_strobes", 32'({bif.load_MAR, bif.load_MDR, bif.CS, bif.MDR_bus}), 32'd0);
    check("mid_rst_bus_req", 32'(bif.bus_req), 32'd0);
    check("mid_rst_R_NW", 32'(bif.R_NW), 32'd1);
    check("mid_rst_rsp_valid", 32'(bif.rsp_valid), 32'd0);
    check("mid_rst_req_ready", 32'(bif.req_ready), 32'd1);
    repeat (2) @(negedge clock);
    n_reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("post_rst_no_rsp", 32'(bif.rsp_valid), 32'd0);
    end
    run_txn(1'b0, 5'h1C, 8'h00, 0, "rd1C_post_rst");
    run_txn(1'b1, 5'h1C, 8'h99, 0, "wr1C_post_rst");
    run_txn(1'b0, 5'h1C, 8'h00, 1, "rd1C_again");

    // Randomized transactions
    for (int t = 0; t < 40; t++) begin
      run_txn(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
              8'($urandom), int'($urandom_range(0, 3)), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time bound so the bench always terminates
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "timeout");
  end

endmodule
